// File: rtl/branch_bht_unit.sv
// Branch resolve unit with a 2-bit saturating-counter BHT.
// Define BR_GSHARE_EN for gshare indexing (GHR XOR PC); bimodal otherwise.
module branch_bht_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [3:0]      ex_br_type,
  input  logic [XLEN-1:0] ex_src0,
  input  logic [XLEN-1:0] ex_src1,
  input  logic            ex_pred_taken,
  output logic [1:0]      npc_sel,
  output logic            mispredict
);

  localparam logic [3:0] BR_BEQ  = 4'b0001;
  localparam logic [3:0] BR_BNE  = 4'b0010;
  localparam logic [3:0] BR_BLT  = 4'b0011;
  localparam logic [3:0] BR_BGE  = 4'b0100;
  localparam logic [3:0] BR_BLTU = 4'b0101;
  localparam logic [3:0] BR_BGEU = 4'b0110;
  localparam logic [3:0] BR_JAL  = 4'b1001;
  localparam logic [3:0] BR_JALR = 4'b1000;

  localparam logic [1:0] NPC_NONE = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JALR = 2'b10;
  localparam logic [1:0] NPC_FALL = 2'b11;

  logic [1:0]       bht_q [BHT_DEPTH];
  logic [1:0]       bht_d [BHT_DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             is_cond;
  logic             is_jal;
  logic             is_jalr;
  logic             taken;
  logic             train;
  logic             eq;
  logic             lt_s;
  logic             lt_u;

`ifdef BR_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;
  logic [IDX_W-1:0] ghr_d;

  assign if_idx = if_pc[IDX_W+1:2] ^ ghr_q;
  assign ex_idx = ex_pc[IDX_W+1:2] ^ ghr_q;

  always_comb begin
    ghr_d = ghr_q;
    if (train) ghr_d = {ghr_q[IDX_W-2:0], taken};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end
`else
  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
`endif

  assign eq   = (ex_src0 == ex_src1);
  assign lt_s = ($signed(ex_src0) < $signed(ex_src1));
  assign lt_u = (ex_src0 < ex_src1);

  always_comb begin
    is_cond = 1'b0;
    is_jal  = 1'b0;
    is_jalr = 1'b0;
    taken   = 1'b0;
    case (ex_br_type)
      BR_BEQ:  begin is_cond = 1'b1; taken = eq;    end
      BR_BNE:  begin is_cond = 1'b1; taken = !eq;   end
      BR_BLT:  begin is_cond = 1'b1; taken = lt_s;  end
      BR_BGE:  begin is_cond = 1'b1; taken = !lt_s; end
      BR_BLTU: begin is_cond = 1'b1; taken = lt_u;  end
      BR_BGEU: begin is_cond = 1'b1; taken = !lt_u; end
      BR_JAL:  is_jal  = 1'b1;
      BR_JALR: is_jalr = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    npc_sel = NPC_NONE;
    if (ex_valid) begin
      if (is_jal) npc_sel = NPC_BR;
      else if (is_jalr) npc_sel = NPC_JALR;
      else if (is_cond && taken && !ex_pred_taken) npc_sel = NPC_BR;
      else if (is_cond && !taken && ex_pred_taken) npc_sel = NPC_FALL;
    end
  end

  assign mispredict = (npc_sel != NPC_NONE);

  // Stalled EX still redirects combinationally but only trains once released.
  assign train = ex_valid && !ex_stall && is_cond;

  assign if_pred_taken = bht_q[if_idx][1];

  always_comb begin
    for (int i = 0; i < BHT_DEPTH; i++) bht_d[i] = bht_q[i];
    if (train) begin
      if (taken && bht_q[ex_idx] != 2'b11)
        bht_d[ex_idx] = bht_q[ex_idx] + 2'd1;
      else if (!taken && bht_q[ex_idx] != 2'b00)
        bht_d[ex_idx] = bht_q[ex_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
    end else begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= bht_d[i];
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                            ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

endmodule
